multicycle_controller: RTL

Main control unit for the multicycle RV32I core: a Moore state machine that sequences one shared ALU, one unified instruction/data memory port, the register file and the immediate extender across several cycles per instruction. It decodes opcode/funct fields from the instruction register and drives every datapath select, including `immsrc` to the immediate extender, plus write enables and ALU control. It sits beside the datapath; memory waits are handled with a ready handshake.

---
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences ALU, unified memory port, regfile and immext (ILLEGAL trap via MULTICYCLE_CTRL_ILLEGAL_TRAP_EN).
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles; outputs are combinational from state and instruction fields.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while mem_ready is low; all other states ignore it.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        ,
        ILLEGAL
`endif
    } state_t;

    state_t     state, state_n;
    logic [1:0] aluop;
    logic       branch;
    logic       pcupdate;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        aluop     = 2'b00;
        branch    = 1'b0;
        pcupdate  = 1'b0;
        illegal   = 1'b0;
        case (state)
            FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                pcupdate  = mem_ready;
                if (mem_ready) state_n = DECODE;
            end
            DECODE: begin
                // Precompute PC-relative target while the opcode is decoded
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_R:         state_n = EXECUTER;
                    OP_I:         state_n = EXECUTEI;
                    OP_BEQ:       state_n = BEQ;
                    OP_JAL:       state_n = JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:      state_n = ILLEGAL;
`else
                    default:      state_n = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_n = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) state_n = MEMWB;
            end
            MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                state_n   = FETCH;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) state_n = FETCH;
            end
            EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_n = ALUWB;
            end
            EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_n = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                state_n  = FETCH;
            end
            BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
                state_n = FETCH;
            end
            JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_n  = ALUWB;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            ILLEGAL: begin
                // Sticky trap: only reset leaves this state
                illegal = 1'b1;
                state_n = ILLEGAL;
            end
`endif
            default: state_n = FETCH;
        endcase
    end

    assign pcwrite = pcupdate | (branch & zero);

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    // funct7b5 selects sub only for register-register ops
                    3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule
